// File: rtl/msfsm_pkg.sv
// Shared types and net tables for the transition firing sequencer:
// place/transition counts, initial marking, PRE/POST incidence masks and FSM states.
package msfsm_pkg;

  localparam int unsigned N_PLACES = 10;
  localparam int unsigned N_TRANS  = 8;

  typedef logic [N_PLACES-1:0] marking_t;

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    FIRE,
    STALL
  } state_t;

  // Bit n of a mask is place pn.
  localparam marking_t INIT_MARKING = 10'b10_1100_1000;  // p3 p6 p7 p9

  localparam marking_t PRE [N_TRANS] = '{
    10'b10_1100_1000,  // t0: p3 p6 p7 p9
    10'b00_0000_0001,  // t1: p0
    10'b00_0000_0100,  // t2: p2
    10'b00_0001_0010,  // t3: p1 p4
    10'b00_0010_0000,  // t4: p5
    10'b01_0000_0000,  // t5: p8
    10'b00_0100_0100,  // t6: p2 p6
    10'b10_0000_0000   // t7: p9
  };

  localparam marking_t POST [N_TRANS] = '{
    10'b01_0011_0001,  // t0: p0 p4 p5 p8
    10'b00_0000_0100,  // t1: p2
    10'b00_0000_1010,  // t2: p1 p3
    10'b00_0100_0000,  // t3: p6
    10'b00_1000_0000,  // t4: p7
    10'b10_0000_0000,  // t5: p9
    10'b00_0000_0001,  // t6: p0
    10'b00_0000_1000   // t7: p3
  };

endpackage

// File: rtl/msfsm_marking_reg.sv
// Place marking register with enablement compare and external token injection;
// injection is merged after any firing update so an injected token always survives.
module msfsm_marking_reg
  import msfsm_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  marking_t            pre,
  input  marking_t            post,
  input  logic                fire_upd,
  input  logic                inj_valid,
  input  logic [3:0]          inj_place,
  output marking_t            marking,
  output logic                enabled
);

  marking_t inj_mask;
  marking_t marking_nxt;

  always_comb begin
    inj_mask = '0;
    if (inj_valid && (inj_place < 4'(N_PLACES))) begin
      inj_mask[inj_place] = 1'b1;
    end
    marking_nxt = marking;
    if (fire_upd) begin
      marking_nxt = (marking & ~pre) | post;
    end
    marking_nxt = marking_nxt | inj_mask;
  end

  assign enabled = ((marking & pre) == pre);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      marking <= INIT_MARKING;
    end else begin
      marking <= marking_nxt;
    end
  end

endmodule

// File: rtl/msfsm_trans_seq.sv
// Accepts one transition request at a time, waits for enablement, fires it as a
// one-cycle one-hot strobe or rejects after STALL_MAX cycles. MSFSM_SAFETY_CHECK_EN adds sticky err.
module msfsm_trans_seq
  import msfsm_pkg::*;
#(
  parameter int unsigned STALL_MAX = 15,
  parameter int unsigned DW        = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  input  logic [2:0]          req_id,
  input  logic [DW-1:0]       req_data,
  output logic                req_ready,
  input  logic                inj_valid,
  input  logic [3:0]          inj_place,
  output logic [N_TRANS-1:0]  t_fire,
  output logic [DW-1:0]       data,
  output logic                rej,
  output logic [N_PLACES-1:0] marking,
  output logic                err
);

  localparam logic [3:0] STALL_LAST = 4'(STALL_MAX);

  state_t             state, state_nxt;
  logic [2:0]         id_q;
  logic [DW-1:0]      data_q;
  logic [3:0]         cnt, cnt_nxt;
  logic               rej_nxt;
  logic               enabled;
  logic               fire_upd;
  marking_t           pre, post;
  logic [N_TRANS-1:0] fire_vec;

  assign pre       = PRE[id_q];
  assign post      = POST[id_q];
  assign req_ready = (state == IDLE);
  assign fire_upd  = (state == FIRE);

  always_comb begin
    fire_vec       = '0;
    fire_vec[id_q] = 1'b1;
  end

  msfsm_marking_reg u_marking (
    .clk       (clk),
    .reset     (reset),
    .pre       (pre),
    .post      (post),
    .fire_upd  (fire_upd),
    .inj_valid (inj_valid),
    .inj_place (inj_place),
    .marking   (marking),
    .enabled   (enabled)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rej_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid) state_nxt = EVAL;
      end
      EVAL: begin
        cnt_nxt   = '0;
        state_nxt = enabled ? FIRE : STALL;
      end
      STALL: begin
        if (enabled) begin
          state_nxt = FIRE;
          cnt_nxt   = '0;
        end else if (cnt + 4'd1 == STALL_LAST) begin
          state_nxt = IDLE;
          rej_nxt   = 1'b1;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      FIRE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Strobe and payload are registered on entry to FIRE so they cover exactly the FIRE cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      id_q   <= '0;
      data_q <= '0;
      cnt    <= '0;
      t_fire <= '0;
      data   <= '0;
      rej    <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      rej   <= rej_nxt;
      if (req_ready && req_valid) begin
        id_q   <= req_id;
        data_q <= req_data;
      end
      if (state_nxt == FIRE) begin
        t_fire <= fire_vec;
        data   <= data_q;
      end else begin
        t_fire <= '0;
        data   <= '0;
      end
    end
  end

`ifdef MSFSM_SAFETY_CHECK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err <= 1'b0;
    end else if (fire_upd && ((marking & ~pre & post) != '0)) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_msfsm_trans_seq.sv
// Scoreboarded random/directed bench for msfsm_trans_seq against a transaction-level Petri-net model.
`timescale 1ns/1ps
module tb_msfsm_trans_seq;

  localparam int DW = 8;

  localparam logic [9:0] INIT_M = 10'b10_1100_1000;
  localparam logic [9:0] PRE_M [8] = '{
    10'b10_1100_1000, 10'b00_0000_0001, 10'b00_0000_0100, 10'b00_0001_0010,
    10'b00_0010_0000, 10'b01_0000_0000, 10'b00_0100_0100, 10'b10_0000_0000};
  localparam logic [9:0] POST_M [8] = '{
    10'b01_0011_0001, 10'b00_0000_0100, 10'b00_0000_1010, 10'b00_0100_0000,
    10'b00_1000_0000, 10'b10_0000_0000, 10'b00_0000_0001, 10'b00_0000_1000};

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid = 1'b0;
  logic [2:0]    req_id = '0;
  logic [DW-1:0] req_data = '0;
  logic          req_ready;
  logic          inj_valid = 1'b0;
  logic [3:0]    inj_place = '0;
  logic [7:0]    t_fire;
  logic [DW-1:0] data;
  logic          rej;
  logic [9:0]    marking;
  logic          err;

  msfsm_trans_seq #(.STALL_MAX(15), .DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_id    (req_id),
    .req_data  (req_data),
    .req_ready (req_ready),
    .inj_valid (inj_valid),
    .inj_place (inj_place),
    .t_fire    (t_fire),
    .data      (data),
    .rej       (rej),
    .marking   (marking),
    .err       (err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]    tf;
    logic [DW-1:0] d;
    logic          rj;
    int unsigned   at;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [9:0]  m;
  logic        err_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe or reject must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && (t_fire !== 8'h00 || rej !== 1'b0)) begin
        if (sb.size() == 0) begin
          check("unexpected_output", {23'b0, t_fire, rej}, 32'(0));
        end else begin
          e = sb.pop_front();
          check("t_fire", 32'(t_fire), 32'(e.tf));
          check("rej", 32'(rej), 32'(e.rj));
          check("event_cycle", cyc, e.at);
          if (!e.rj) check("data", 32'(data), 32'(e.d));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic pick_inj(input int s, input int dir_s, input logic [3:0] dir_p,
                          input bit rnd, output logic [9:0] mask);
    logic       v;
    logic [3:0] p;
    v = 1'b0;
    p = '0;
    if (rnd) begin
      v = ($urandom_range(0, 5) == 0);
      p = 4'($urandom_range(0, 15));
    end else if (s == dir_s) begin
      v = 1'b1;
      p = dir_p;
    end
    inj_valid = v;
    inj_place = p;
    mask = (v && p < 4'd10) ? (10'b1 << p) : 10'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    req_valid = 1'b0;
    inj_valid = 1'b0;
    m = INIT_M;
    err_m = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic inj_idle(input logic [3:0] p);
    inj_valid = 1'b1;
    inj_place = p;
    if (p < 4'd10) m = m | (10'b1 << p);
    @(negedge clk);
    inj_valid = 1'b0;
  endtask

  // Issue one request starting at a negedge with the DUT idle; returns at the negedge it is idle again.
  task automatic do_req(input logic [2:0] id, input logic [DW-1:0] d, input bit b2b,
                        input int dir_s, input logic [3:0] dir_p, input bit rnd, input bit rst_in_fire);
    int unsigned a;
    logic [9:0]  inj;
    logic        unsafe;
    exp_t        e;
    check("ready_idle", 32'(req_ready), 32'(1));
    check("marking", 32'(marking), 32'(m));
    check("err", 32'(err), 32'(err_m));
    req_valid = 1'b1;
    req_id    = id;
    req_data  = d;
    inj_valid = 1'b0;
    a = cyc + 1;
    @(negedge clk);
    if (!b2b) req_valid = 1'b0;
    for (int unsigned j = 0; j < 16; j++) begin
      check("ready_busy", 32'(req_ready), 32'(0));
      if ((m & PRE_M[id]) == PRE_M[id]) begin
        pick_inj(int'(j), dir_s, dir_p, rnd, inj);
        m = m | inj;
        unsafe = ((m & ~PRE_M[id] & POST_M[id]) != 10'b0);
        if (rst_in_fire) begin
          @(posedge clk);
          #1;
          check("fire_before_reset", 32'(t_fire), 32'(8'b1 << id));
          reset = 1'b0;
          #1;
          check("rst_t_fire", 32'(t_fire), 32'(0));
          check("rst_data", 32'(data), 32'(0));
          check("rst_marking", 32'(marking), 32'(INIT_M));
          check("rst_ready", 32'(req_ready), 32'(1));
          m = INIT_M;
          err_m = 1'b0;
          req_valid = 1'b0;
          inj_valid = 1'b0;
          @(negedge clk);
          reset = 1'b1;
        end else begin
          e.tf = 8'b1 << id;
          e.d  = d;
          e.rj = 1'b0;
          e.at = a + j + 1;
          sb.push_back(e);
          @(negedge clk);
          check("ready_fire", 32'(req_ready), 32'(0));
          pick_inj(int'(j) + 1, dir_s, dir_p, rnd, inj);
          m = ((m & ~PRE_M[id]) | POST_M[id]) | inj;
`ifdef MSFSM_SAFETY_CHECK_EN
          err_m = err_m | unsafe;
`endif
          @(negedge clk);
        end
        break;
      end
      pick_inj(int'(j), dir_s, dir_p, rnd, inj);
      m = m | inj;
      if (j == 15) begin
        e.tf = 8'h00;
        e.d  = '0;
        e.rj = 1'b1;
        e.at = a + 16;
        sb.push_back(e);
      end
      @(negedge clk);
    end
    inj_valid = 1'b0;
  endtask

  initial begin
    m = INIT_M;
    err_m = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_t_fire", 32'(t_fire), 32'(0));
    check("reset_data", 32'(data), 32'(0));
    check("reset_rej", 32'(rej), 32'(0));
    check("reset_err", 32'(err), 32'(0));
    check("reset_marking", 32'(marking), 32'(INIT_M));
    reset = 1'b1;

    // t0 fires immediately from the initial marking
    do_req(3'd0, 8'hA5, 1'b0, -1, 4'd0, 1'b0, 1'b0);
    check("t0_marking", 32'(marking), 32'(10'b01_0011_0001));

    // t1 stalls, p0 injected during stall cycle 3, then fires
    apply_reset();
    do_req(3'd1, 8'h3C, 1'b0, 3, 4'd0, 1'b0, 1'b0);
    check("t1_marking", 32'(marking), 32'(10'b10_1100_1100));

    // t1 never enabled: reject, marking untouched
    apply_reset();
    do_req(3'd1, 8'h11, 1'b0, -1, 4'd0, 1'b0, 1'b0);
    check("rej_marking", 32'(marking), 32'(INIT_M));

    // p5 injected in the FIRE cycle of t0 survives the update
    do_req(3'd0, 8'h5A, 1'b0, 1, 4'd5, 1'b0, 1'b0);
    check("coincident_inj_marking", 32'(marking), 32'(10'b01_0011_0001));

    // p5 pre-marked before t0: unsafe firing (err only with the safety check built in)
    apply_reset();
    inj_idle(4'd5);
    inj_idle(4'd12);
    do_req(3'd0, 8'h42, 1'b0, -1, 4'd0, 1'b0, 1'b0);
    do_req(3'd1, 8'h43, 1'b0, -1, 4'd0, 1'b0, 1'b0);

    // reset during FIRE, then a normal request right after release
    apply_reset();
    do_req(3'd0, 8'h77, 1'b0, -1, 4'd0, 1'b0, 1'b1);
    do_req(3'd0, 8'h78, 1'b0, -1, 4'd0, 1'b0, 1'b0);

    // back-to-back requests with valid held high
    apply_reset();
    do_req(3'd0, 8'h01, 1'b1, -1, 4'd0, 1'b0, 1'b0);
    do_req(3'd1, 8'h02, 1'b1, -1, 4'd0, 1'b0, 1'b0);
    do_req(3'd4, 8'h03, 1'b1, -1, 4'd0, 1'b0, 1'b0);
    req_valid = 1'b0;

    // randomized requests with random injections
    for (int unsigned n = 0; n < 40; n++) begin
      logic b2b;
      b2b = 1'($urandom_range(0, 1));
      do_req(3'($urandom_range(0, 7)), 8'($urandom), b2b, -1, 4'd0, 1'b1, 1'b0);
      if (!b2b) begin
        req_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("final_marking", 32'(marking), 32'(m));
    check("scoreboard_drained", 32'(sb.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
